// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_pkg
// Purpose  : Shared definitions for the load/store sequencer: access size
//            codes, sequencer state encoding, the default data-memory limit
//            and small helpers for alignment checks and byte enables.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam logic [31:0] ADDR_LIMIT_DEFAULT = 32'h0000_2000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    // Misaligned, illegal size or beyond the end of data memory.
    function automatic logic addr_error(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input logic [31:0] limit);
        logic bad;
        bad = (addr >= limit);
        case (size)
            SZ_BYTE: bad = bad;
            SZ_HALF: bad = bad | addr[0];
            SZ_WORD: bad = bad | (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                                input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_extract.sv
`default_nettype none
// ============================================================================
// Module   : load_extract
// Purpose  : Combinational lane select and sign/zero extension of a memory
//            word for byte, halfword and word loads.
// Ports    : i_word     - 32-bit word read from memory
//            i_addr_lo  - byte offset within the word
//            i_size     - access size code
//            i_sign_ext - 1 sign-extend, 0 zero-extend (sub-word only)
//            o_data     - right-aligned, extended result
// Revision : 1.0 - initial release
// ============================================================================
module load_extract
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

        case (i_size)
            SZ_BYTE: o_data = {{24{i_sign_ext & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{i_sign_ext & w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Load/store sequencer between the CPU controller and the
//            word-organised data memory. Accepts one request per handshake,
//            checks alignment/range, drives byte enables and a one-cycle
//            write strobe, and holds the extended load result (MDR).
// Ports    : clk, reset        - clock, synchronous active-high reset
//            i_req/i_we/i_size/i_sign_ext/i_addr/i_wdata - request fields
//            o_busy/o_done/o_err_load/o_err_store       - controller status
//            o_load_data                                - load result
//            o_mem_we/o_mem_be/o_mem_addr/o_mem_wdata   - memory request
//            i_mem_rdata                                - memory read word
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err_load,
    output logic        o_err_store,
    output logic [31:0] o_load_data,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_sign_ext;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_load_data;
    logic [31:0] w_extracted;
    logic        w_accept;

    // Requests are only looked at in IDLE; anything arriving while busy,
    // including in the DONE/ERR cycle, is dropped.
    assign w_accept = (r_state == IDLE) && i_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        o_err_load   = 1'b0;
        o_err_store  = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_be     = 4'b0000;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_req) begin
                    if (addr_error(i_size, i_addr, ADDR_LIMIT)) begin
                        w_next_state = ERR;
                    end else if (i_we) begin
                        w_next_state = WRITE;
                    end else begin
                        w_next_state = READ;
                    end
                end
            end
            WRITE: begin
                o_mem_we     = 1'b1;
                o_mem_be     = byte_enables(r_size, r_addr[1:0]);
                w_next_state = DONE;
            end
            READ: begin
                w_next_state = DONE;
            end
            DONE: begin
                o_done       = 1'b1;
                w_next_state = IDLE;
            end
            ERR: begin
                o_done       = 1'b1;
                o_err_load   = ~r_we;
                o_err_store  = r_we;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_size      <= SZ_BYTE;
            r_sign_ext  <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_load_data <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we       <= i_we;
                r_size     <= i_size;
                r_sign_ext <= i_sign_ext;
                r_addr     <= i_addr;
                r_wdata    <= i_wdata;
            end
            if (r_state == READ) begin
                r_load_data <= w_extracted;
            end
        end
    end

    load_extract u_load_extract (
        .i_word     (i_mem_rdata),
        .i_addr_lo  (r_addr[1:0]),
        .i_size     (r_size),
        .i_sign_ext (r_sign_ext),
        .o_data     (w_extracted)
    );

    assign o_load_data = r_load_data;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit. A word-organised data
//            memory sits on the memory port; a byte-addressed reference
//            model predicts store effects, load results and error responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam logic [31:0] LIMIT = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, err_load, err_store, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_words [0:2047];
    logic [7:0]  ref_bytes [0:8191];
    logic [31:0] exp_ld = 32'd0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req       (req),
        .i_we        (we),
        .i_size      (size),
        .i_sign_ext  (sign_ext),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_busy      (busy),
        .o_done      (done),
        .o_err_load  (err_load),
        .o_err_store (err_store),
        .o_load_data (load_data),
        .o_mem_we    (mem_we),
        .o_mem_be    (mem_be),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    // Data memory: right-aligned store data is placed into lanes by enable.
    function automatic logic [7:0] lane_data(input logic [3:0] be, input logic [31:0] d, input int l);
        if (be == 4'hF) return d[8*l +: 8];
        if (be == 4'b1100 || be == 4'b0011) return d[8*(l%2) +: 8];
        return d[7:0];
    endfunction

    assign mem_rdata = (mem_addr < LIMIT) ? mem_words[mem_addr[12:2]] : 32'd0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2048; i++) mem_words[i] <= 32'd0;
        end else if (mem_we && mem_addr < LIMIT) begin
            for (int l = 0; l < 4; l++)
                if (mem_be[l]) mem_words[mem_addr[12:2]][8*l +: 8] <= lane_data(mem_be, mem_wdata, l);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 8192; i++) ref_bytes[i] = 8'h00;
        exp_ld = 32'd0;
    endtask

    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // One complete request; extra keeps req high through the first busy cycle.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d, input logic extra);
        logic        bad;
        int          n;
        logic [31:0] v;
        n   = nbytes_of(sz);
        bad = (sz == 2'b11) || (a >= LIMIT) || (a % n != 0);
        @(negedge clk);
        we = w; size = sz; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
        @(posedge clk); #1;
        req = extra;
        check("busy_c1", {31'd0, busy}, 32'd1);
        if (bad) begin
            check("err_done_c1", {31'd0, done}, 32'd1);
            check("err_load", {31'd0, err_load}, {31'd0, ~w});
            check("err_store", {31'd0, err_store}, {31'd0, w});
            check("err_mem_we", {31'd0, mem_we}, 32'd0);
            check("err_mem_be", {28'd0, mem_be}, 32'd0);
            @(posedge clk); #1;
            req = 1'b0;
            check("err_done_c2", {31'd0, done}, 32'd0);
            check("err_busy_c2", {31'd0, busy}, 32'd0);
            check("err_ld_kept", load_data, exp_ld);
        end else if (w) begin
            check("st_mem_we", {31'd0, mem_we}, 32'd1);
            check("st_mem_be", {28'd0, mem_be}, {28'd0, 4'(((1 << n) - 1) << (a % 4))});
            check("st_mem_addr", mem_addr, a);
            check("st_mem_wdata", mem_wdata, d);
            check("st_done_c1", {31'd0, done}, 32'd0);
            for (int i = 0; i < n; i++) ref_bytes[a + i] = d[8*i +: 8];
            @(posedge clk); #1;
            req = 1'b0;
            check("st_done_c2", {31'd0, done}, 32'd1);
            check("st_errs", {30'd0, err_load, err_store}, 32'd0);
            check("st_mem_we_c2", {31'd0, mem_we}, 32'd0);
            @(posedge clk); #1;
            check("st_busy_c3", {31'd0, busy}, 32'd0);
        end else begin
            check("ld_mem_we", {31'd0, mem_we}, 32'd0);
            check("ld_done_c1", {31'd0, done}, 32'd0);
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_bytes[a + i];
            if (sx && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            exp_ld = v;
            @(posedge clk); #1;
            req = 1'b0;
            check("ld_done_c2", {31'd0, done}, 32'd1);
            check("ld_errs", {30'd0, err_load, err_store}, 32'd0);
            check("ld_data", load_data, exp_ld);
            @(posedge clk); #1;
            check("ld_busy_c3", {31'd0, busy}, 32'd0);
            check("ld_data_hold", load_data, exp_ld);
        end
    endtask

    initial begin
        int ndone;
        logic [31:0] a;
        clear_ref();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_errs", {30'd0, err_load, err_store}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        reset = 1'b0;

        // Directed cases
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5, 1'b0);
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234, 1'b0);
        do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h80FF7F01, 1'b0);
        do_req(1'b0, 2'b00, 1'b1, 32'h42, 32'h0, 1'b0);
        check("sbyte_0x42", load_data, 32'hFFFFFFFF);
        do_req(1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 1'b0);
        check("ubyte_0x43", load_data, 32'h00000080);
        do_req(1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 1'b0);
        check("shalf_0x40", load_data, 32'h00007F01);
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);
        check("word_0x40", load_data, 32'h80FF7F01);
        do_req(1'b0, 2'b01, 1'b1, 32'h41, 32'h0, 1'b0);
        do_req(1'b1, 2'b10, 1'b0, 32'h2000, 32'h12345678, 1'b0);
        do_req(1'b0, 2'b11, 1'b0, 32'h44, 32'h0, 1'b0);
        do_req(1'b1, 2'b00, 1'b0, 32'h1FFF, 32'h0000005A, 1'b1);
        do_req(1'b0, 2'b00, 1'b1, 32'h1FFF, 32'h0, 1'b1);

        // Reset coinciding with the WRITE cycle of a store
        @(negedge clk);
        we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h80; wdata = 32'hCAFEF00D; req = 1'b1;
        @(posedge clk); #1;
        check("rw_mem_we", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; req = 1'b0;
        clear_ref();
        check("rw_busy", {31'd0, busy}, 32'd0);
        check("rw_done", {31'd0, done}, 32'd0);
        check("rw_mem_we_after", {31'd0, mem_we}, 32'd0);
        check("rw_load_data", load_data, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b0);
        check("rw_not_committed", load_data, 32'd0);

        // Held req across the busy cycle: exactly one done
        @(negedge clk);
        we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h84; wdata = 32'h01020304; req = 1'b1;
        for (int i = 0; i < 4; i++) ref_bytes[32'h84 + i] = wdata[8*i +: 8];
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) req = 1'b0;
            if (done) ndone++;
        end
        check("one_done_per_req", ndone, 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'h84, 32'h0, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 15) == 0) a = 32'h1FF0 + $urandom_range(0, 63);
            else a = $urandom_range(0, 127);
            if ($urandom_range(0, 2) != 0) a = a & ~32'h3 | (a & (32'h3 >> $urandom_range(0, 2)));
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer between the multi-cycle CPU control/datapath and the word-organised data memory.
- Accepts one load or store request per handshake and checks alignment and address range.
- Generates the byte-enable/write strobe for the memory and returns a registered, sign- or zero-extended load result (MDR role).
- Reports address-error exceptions back to the controller.

Parameters:
- ADDR_LIMIT, 32'h0000_2000, first byte address beyond data memory; any address >= this is an error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  1  request strobe from controller; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- sign_ext  in  1  loads only: 1 sign-extend, 0 zero-extend
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse (success or error)
- err_load  out  1  load address error, valid with done
- err_store  out  1  store address error, valid with done
- load_data  out  32  extended load result, held until next successful load
- mem_we  out  1  memory write strobe
- mem_be  out  4  byte enables
- mem_addr  out  32  byte address to memory
- mem_wdata  out  32  store data to memory, right-aligned
- mem_rdata  in  32  combinational read word from memory at mem_addr

Behaviour:
- Reset values:
  - State IDLE.
  - busy, done, err_load, err_store, mem_we are 0.
  - mem_be is 4'b0000.
  - mem_addr, mem_wdata and load_data are 0.
- States:
  - IDLE: on req, latch we/size/sign_ext/addr/wdata.
    - Error -> ERR.
    - Else store -> WRITE.
    - Else load -> READ.
  - WRITE: mem_we=1 for exactly this cycle with latched mem_be/mem_addr/mem_wdata -> DONE.
  - READ: mem_we=0; load_data captured from mem_rdata at the end of this cycle -> DONE.
  - DONE: done=1 -> IDLE.
  - ERR: done=1, and err_load or err_store per latched we; no memory access, load_data unchanged -> IDLE.
- Error conditions, evaluated on input fields at acceptance:
  - size=11.
  - Half with addr[0]=1.
  - Word with addr[1:0]!=0.
  - addr >= ADDR_LIMIT.
- Latency:
  - Request accepted at edge 0.
  - mem_we high in cycle 1 for a store.
  - done high in cycle 2 for load and store alike; load_data valid from that cycle.
  - Errors give done in cycle 1.
- mem_be:
  - Byte: 4'b0001 << addr[1:0].
  - Half: addr[1] ? 4'b1100 : 4'b0011.
  - Word: 4'b1111.
  - mem_be is 0 outside WRITE; the memory places right-aligned data by enable.
- Load extraction:
  - Byte: lane addr[1:0].
  - Half: lane addr[1].
  - The selected lane is extended to 32 bits per sign_ext; word loads pass through.
- req while busy is ignored, not queued; the controller holds req until done.
- done asserted and a new req in the same cycle: the new req is taken only once the state is IDLE, i.e. the next cycle.
- Reset mid-operation: after the reset edge the state is IDLE, mem_we=0 and done=0. An in-flight store whose WRITE cycle coincides with the reset edge is not committed; the memory also clears on the same reset.
- mem_addr and mem_wdata hold the latched values between requests.

Decomposition:
- Shared package holds:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD;
  - state encoding IDLE/WRITE/READ/DONE/ERR;
  - ADDR_LIMIT default.
- One combinational sub-module, load_extract: inputs are the word, addr[1:0], size and sign_ext; output is the 32-bit extended value. Reused by any future cache-fill path.

Test Plan:
- Word store: addr=0x10, wdata=0xDEADBEEF.
  - Required response: cycle 1 has mem_we=1, mem_be=1111, mem_addr=0x10; cycle 2 has done=1 and no error.
- Byte store: addr=0x13, wdata=0x000000A5.
  - Required response: mem_be=1000, mem_wdata=0x000000A5.
- Half store at addr=0x22:
  - Required response: mem_be=1100.
- Loads with memory word 0x80FF7F01 at 0x40:
  - Signed byte, addr 0x42 -> load_data 0xFFFFFFFF.
  - Unsigned byte, addr 0x43 -> 0x00000080.
  - Signed half, addr 0x40 -> 0x00007F01.
  - Word -> 0x80FF7F01.
- Errors:
  - Half load at 0x41 -> done in cycle 1, err_load=1, mem_we never high, load_data unchanged.
  - Word store at 0x2000 -> err_store=1.
  - size=11 -> error flagged.
- Reset during WRITE cycle:
  - Required response: next cycle busy=0, done=0, mem_we=0.
  - Then req while busy: an extra req pulse in cycle 1 is ignored, giving exactly one done per accepted request.
